bus_width_converter: RTL and testbench

Parametrised bus width converter with valid/ready handshakes on both sides. It upsizes by packing narrow beats into wide words, downsizes by serialising wide words into narrow beats, or passes through when the widths are equal. Packet boundaries are carried on `last`, and per-lane `keep` masks describe partial words. It sits between streaming FIFOs and bus endpoints of differing width.

---
 rtl/bus_width_pkg.sv | 18 +
 rtl/bus_width_serializer.sv | 79 +++++++
 rtl/bus_width_converter.sv | 139 +++++++++++++
 tb/tb_bus_width_converter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_width_pkg.sv
// Shared constant functions for the bus width converter: lane geometry and
// the mapping from logical lane order to physical bit slices.
package bus_width_pkg;

  function automatic int lane_f(input int size_in, input int size_out);
    return (size_in < size_out) ? size_in : size_out;
  endfunction

  function automatic int ratio_f(input int size_in, input int size_out);
    return (size_in < size_out) ? size_out / size_in : size_in / size_out;
  endfunction

  // Physical slot of logical lane k; the bit-slice base is this value times LANE.
  function automatic int lane_idx_f(input int k, input int ratio, input bit little_endian);
    return little_endian ? k : ratio - 1 - k;
  endfunction

endpackage

// File: rtl/bus_width_serializer.sv
// Downsize path: holds one wide word and emits its valid lanes one per
// output handshake, accepting the next word on the final lane.
module bus_width_serializer
  import bus_width_pkg::*;
#(
  parameter int RATIO         = 4,
  parameter int LANE          = 8,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RATIO*LANE-1:0] in_data,
  input  logic [RATIO-1:0]      in_keep,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANE-1:0]       out_data,
  output logic                  out_last
);
  localparam int LW = $clog2(RATIO);
  localparam int NW = $clog2(RATIO + 1);

  logic [RATIO*LANE-1:0] hold_data_reg;
  logic                  hold_last_reg;
  logic                  busy_reg;
  logic [LW-1:0]         lane_reg;
  logic [NW-1:0]         n_reg;
  logic [NW-1:0]         n_next;
  logic [LANE-1:0]       lane_word [RATIO];
  logic                  final_lane;
  logic                  in_hs;
  logic                  out_hs;

  always_comb begin
    n_next = '0;
    for (int i = 0; i < RATIO; i++) begin
      n_next = n_next + NW'(in_keep[i]);
    end
  end

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign lane_word[gi] = hold_data_reg[lane_idx_f(gi, RATIO, LITTLE_ENDIAN)*LANE +: LANE];
  end

  assign final_lane = (NW'(lane_reg) + NW'(1)) == n_reg;
  assign in_ready   = !busy_reg || (out_ready && final_lane);
  assign in_hs      = in_valid && in_ready;
  assign out_valid  = busy_reg;
  assign out_hs     = busy_reg && out_ready;
  assign out_data   = lane_word[lane_reg];
  assign out_last   = hold_last_reg && final_lane;

  // An empty keep mask is taken but leaves busy clear, so nothing is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_reg <= '0;
      hold_last_reg <= 1'b0;
      busy_reg      <= 1'b0;
      lane_reg      <= '0;
      n_reg         <= '0;
    end else if (in_hs) begin
      hold_data_reg <= in_data;
      hold_last_reg <= in_last;
      n_reg         <= n_next;
      lane_reg      <= '0;
      busy_reg      <= (n_next != '0);
    end else if (out_hs) begin
      if (final_lane) begin
        busy_reg <= 1'b0;
        lane_reg <= '0;
      end else begin
        lane_reg <= lane_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_width_converter.sv
// Valid/ready bus width converter: packs narrow beats into wide words,
// serialises wide words into narrow beats, or registers equal-width beats.
module bus_width_converter
  import bus_width_pkg::*;
#(
  parameter int  SIZE_IN       = 8,
  parameter int  SIZE_OUT      = 32,
  parameter bit  LITTLE_ENDIAN = 1'b1,
  localparam int LANE          = lane_f(SIZE_IN, SIZE_OUT),
  localparam int IN_LANES      = SIZE_IN / LANE,
  localparam int OUT_LANES     = SIZE_OUT / LANE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIZE_IN-1:0]   in_data,
  input  logic [IN_LANES-1:0]  in_keep,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE_OUT-1:0]  out_data,
  output logic [OUT_LANES-1:0] out_keep,
  output logic                 out_last
);
  localparam int RATIO = ratio_f(SIZE_IN, SIZE_OUT);

  if ((SIZE_IN % SIZE_OUT != 0) && (SIZE_OUT % SIZE_IN != 0)) begin : g_bad_ratio
    $error("bus_width_converter: SIZE_IN and SIZE_OUT must divide evenly");
  end

  if (OUT_LANES > 1) begin : g_up
    localparam int CW = $clog2(RATIO);

    logic [CW-1:0]        cnt_reg;
    logic [SIZE_OUT-1:0]  acc_data_reg;
    logic [OUT_LANES-1:0] acc_keep_reg;
    logic [SIZE_OUT-1:0]  word_next;
    logic [OUT_LANES-1:0] keep_next;
    logic [SIZE_OUT-1:0]  out_data_reg;
    logic [OUT_LANES-1:0] out_keep_reg;
    logic                 out_valid_reg;
    logic                 out_last_reg;
    logic                 in_hs;
    logic                 complete;

    assign in_ready  = !out_valid_reg || out_ready;
    assign in_hs     = in_valid && in_ready;
    assign complete  = (cnt_reg == CW'(RATIO - 1)) || in_last;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_keep  = out_keep_reg;
    assign out_last  = out_last_reg;

    // The accumulator is zeroed on every completion, so unfilled lanes stay 0.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
      logic hit;
      assign hit = in_keep[0] && (cnt_reg == CW'(lane_idx_f(gi, RATIO, LITTLE_ENDIAN)));
      assign word_next[gi*LANE +: LANE] = hit ? in_data : acc_data_reg[gi*LANE +: LANE];
      assign keep_next[gi] = hit || acc_keep_reg[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg       <= '0;
        acc_data_reg  <= '0;
        acc_keep_reg  <= '0;
        out_data_reg  <= '0;
        out_keep_reg  <= '0;
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end else begin
        if (out_valid_reg && out_ready) begin
          out_valid_reg <= 1'b0;
        end
        if (in_hs && complete) begin
          out_data_reg  <= word_next;
          out_keep_reg  <= keep_next;
          out_last_reg  <= in_last;
          out_valid_reg <= 1'b1;
          acc_data_reg  <= '0;
          acc_keep_reg  <= '0;
          cnt_reg       <= '0;
        end else if (in_hs) begin
          acc_data_reg <= word_next;
          acc_keep_reg <= keep_next;
          cnt_reg      <= cnt_reg + 1'b1;
        end
      end
    end
  end else if (IN_LANES > 1) begin : g_down
    bus_width_serializer #(
      .RATIO        (RATIO),
      .LANE         (LANE),
      .LITTLE_ENDIAN(LITTLE_ENDIAN)
    ) u_serializer (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_keep  (in_keep),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last)
    );
    assign out_keep = out_valid;
  end else begin : g_pass
    logic [SIZE_OUT-1:0]  out_data_reg;
    logic [OUT_LANES-1:0] out_keep_reg;
    logic                 out_valid_reg;
    logic                 out_last_reg;

    assign in_ready  = !out_valid_reg || out_ready;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_keep  = out_keep_reg;
    assign out_last  = out_last_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_data_reg  <= '0;
        out_keep_reg  <= '0;
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end else if (in_valid && in_ready) begin
        out_data_reg  <= in_data;
        out_keep_reg  <= in_keep;
        out_last_reg  <= in_last;
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_width_converter.sv
// Scoreboard bench for three converter instances: 8->32 LE, 8->32 BE, 32->8 LE.
// Drivers push expected beats; a monitor pops and compares on each output handshake.
module tb_bus_width_converter;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  bit rand_ready = 1'b0;

  logic        i_valid [3];
  logic [31:0] i_data  [3];
  logic [3:0]  i_keep  [3];
  logic        i_last  [3];
  logic        o_ready [3];

  logic        ule_in_ready, ule_out_valid, ule_out_last;
  logic [31:0] ule_out_data;
  logic [3:0]  ule_out_keep;
  logic        ube_in_ready, ube_out_valid, ube_out_last;
  logic [31:0] ube_out_data;
  logic [3:0]  ube_out_keep;
  logic        dn_in_ready, dn_out_valid, dn_out_last;
  logic [7:0]  dn_out_data;
  logic        dn_out_keep;

  exp_t       sb_q [3][$];
  logic [7:0] pend [2][$];

  bus_width_converter #(.SIZE_IN(8), .SIZE_OUT(32), .LITTLE_ENDIAN(1'b1)) u_up_le (
    .clk(clk), .rst_n(rst_n), .in_valid(i_valid[0]), .in_ready(ule_in_ready),
    .in_data(i_data[0][7:0]), .in_keep(i_keep[0][0]), .in_last(i_last[0]),
    .out_valid(ule_out_valid), .out_ready(o_ready[0]), .out_data(ule_out_data),
    .out_keep(ule_out_keep), .out_last(ule_out_last)
  );

  bus_width_converter #(.SIZE_IN(8), .SIZE_OUT(32), .LITTLE_ENDIAN(1'b0)) u_up_be (
    .clk(clk), .rst_n(rst_n), .in_valid(i_valid[1]), .in_ready(ube_in_ready),
    .in_data(i_data[1][7:0]), .in_keep(i_keep[1][0]), .in_last(i_last[1]),
    .out_valid(ube_out_valid), .out_ready(o_ready[1]), .out_data(ube_out_data),
    .out_keep(ube_out_keep), .out_last(ube_out_last)
  );

  bus_width_converter #(.SIZE_IN(32), .SIZE_OUT(8), .LITTLE_ENDIAN(1'b1)) u_down (
    .clk(clk), .rst_n(rst_n), .in_valid(i_valid[2]), .in_ready(dn_in_ready),
    .in_data(i_data[2]), .in_keep(i_keep[2]), .in_last(i_last[2]),
    .out_valid(dn_out_valid), .out_ready(o_ready[2]), .out_data(dn_out_data),
    .out_keep(dn_out_keep), .out_last(dn_out_last)
  );

  function automatic exp_t mk(input logic [31:0] data, input logic [3:0] keep, input logic last);
    exp_t e;
    e.data = data;
    e.keep = keep;
    e.last = last;
    return e;
  endfunction

  function automatic logic get_in_ready(input int d);
    case (d)
      0:       return ule_in_ready;
      1:       return ube_in_ready;
      default: return dn_in_ready;
    endcase
  endfunction

  function automatic logic get_valid(input int d);
    case (d)
      0:       return ule_out_valid;
      1:       return ube_out_valid;
      default: return dn_out_valid;
    endcase
  endfunction

  function automatic exp_t get_out(input int d);
    case (d)
      0:       return mk(ule_out_data, ule_out_keep, ule_out_last);
      1:       return mk(ube_out_data, ube_out_keep, ube_out_last);
      default: return mk({24'h0, dn_out_data}, {3'b000, dn_out_keep}, dn_out_last);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one beat from the next falling edge and hold it until accepted.
  task automatic send(input int d, input logic [31:0] data, input logic [3:0] keep, input logic last);
    bit   done = 1'b0;
    logic hs;
    @(negedge clk);
    i_valid[d] = 1'b1;
    i_data[d]  = data;
    i_keep[d]  = keep;
    i_last[d]  = last;
    for (int t = 0; t < 500 && !done; t++) begin
      #1 hs = get_in_ready(d);
      @(posedge clk);
      if (hs) done = 1'b1;
      else @(negedge clk);
    end
    #1 i_valid[d] = 1'b0;
    $display("dut%0d in  data=%08h keep=%b last=%0d", d, data, keep, last);
    check($sformatf("in_handshake_dut%0d", d), 64'(done), 64'd1);
  endtask

  // Reference packer: gather bytes of a packet, close a word at 4 bytes or last.
  task automatic up_send(input int d, input logic [7:0] b, input logic last, input bit le);
    exp_t e;
    pend[d].push_back(b);
    if (pend[d].size() == 4 || last) begin
      e = '0;
      for (int k = 0; k < pend[d].size(); k++) begin
        int slot;
        slot = le ? k : 3 - k;
        e.data[slot*8 +: 8] = pend[d][k];
        e.keep[slot] = 1'b1;
      end
      e.last = last;
      sb_q[d].push_back(e);
      pend[d].delete();
    end
    send(d, {24'h0, b}, 4'b0001, last);
  endtask

  // Reference splitter: n valid lanes from lane 0 upward, last on the final one.
  task automatic dn_send(input logic [31:0] w, input int n, input logic last);
    for (int k = 0; k < n; k++) begin
      sb_q[2].push_back(mk({24'h0, w[k*8 +: 8]}, 4'b0001, last && (k == n - 1)));
    end
    send(2, w, 4'((1 << n) - 1), last);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    check("drain_empty", 64'(sb_q[0].size() + sb_q[1].size() + sb_q[2].size()), 64'd0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) o_ready[d] = 1'b1;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) o_ready[d] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    exp_t prev [3];
    bit   stall [3];
    exp_t cur;
    exp_t want;
    for (int d = 0; d < 3; d++) stall[d] = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) begin
          stall[d] = 1'b0;
          continue;
        end
        cur = get_out(d);
        if (stall[d]) check($sformatf("hold_dut%0d", d), {get_valid(d), cur}, {1'b1, prev[d]});
        if (get_valid(d) && o_ready[d]) begin
          $display("dut%0d out data=%08h keep=%b last=%0d", d, cur.data, cur.keep, cur.last);
          if (sb_q[d].size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_out_dut%0d: got %0h expected nothing", d, cur);
          end else begin
            want = sb_q[d].pop_front();
            check($sformatf("out_dut%0d", d), cur, want);
          end
        end
        stall[d] = get_valid(d) && !o_ready[d];
        prev[d]  = cur;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      i_valid[d] = 1'b0;
      i_data[d]  = '0;
      i_keep[d]  = '0;
      i_last[d]  = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_out_dut%0d", d), {get_valid(d), get_out(d)}, 64'd0);
      check($sformatf("reset_in_ready_dut%0d", d), 64'(get_in_ready(d)), 64'd1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 8->32 LE: word appears the cycle after the fourth byte.
    sb_q[0].push_back(mk(32'h44332211, 4'b1111, 1'b0));
    send(0, 32'h11, 4'b0001, 1'b0);
    send(0, 32'h22, 4'b0001, 1'b0);
    send(0, 32'h33, 4'b0001, 1'b0);
    check("up_le_no_early_valid", 64'(ule_out_valid), 64'd0);
    send(0, 32'h44, 4'b0001, 1'b0);
    check("up_le_latency", 64'(ule_out_valid), 64'd1);

    // 8->32 BE short packet fills the MSB lanes.
    sb_q[1].push_back(mk(32'hAABB0000, 4'b1100, 1'b1));
    send(1, 32'hAA, 4'b0001, 1'b0);
    send(1, 32'hBB, 4'b0001, 1'b1);

    // 32->8 partial word: three lanes, last on the third.
    sb_q[2].push_back(mk(32'hAA, 4'b0001, 1'b0));
    sb_q[2].push_back(mk(32'hBB, 4'b0001, 1'b0));
    sb_q[2].push_back(mk(32'hCC, 4'b0001, 1'b1));
    send(2, 32'hDDCCBBAA, 4'b0111, 1'b1);
    drain();

    // 32->8 back-to-back words: eight beats without a bubble.
    for (int k = 1; k <= 8; k++) sb_q[2].push_back(mk(32'(k), 4'b0001, k == 8));
    fork
      begin
        send(2, 32'h04030201, 4'b1111, 1'b0);
        send(2, 32'h08070605, 4'b1111, 1'b1);
      end
      begin
        int t = 0;
        do begin
          @(negedge clk);
          #2;
          t++;
        end while (!dn_out_valid && t < 50);
        for (int i = 0; i < 8; i++) begin
          check($sformatf("b2b_valid_beat%0d", i + 1), 64'(dn_out_valid), 64'd1);
          check($sformatf("b2b_in_ready_beat%0d", i + 1), 64'(dn_in_ready), 64'(i == 3 || i == 7));
          @(negedge clk);
          #2;
        end
      end
    join
    drain();

    // Reset after two of four bytes: the partial word must vanish.
    send(0, 32'h01, 4'b0001, 1'b0);
    send(0, 32'h02, 4'b0001, 1'b0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_out_dut0", {get_valid(0), get_out(0)}, 64'd0);
    check("midreset_in_ready_dut0", 64'(ule_in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_q[0].push_back(mk(32'h88776655, 4'b1111, 1'b1));
    send(0, 32'h55, 4'b0001, 1'b0);
    send(0, 32'h66, 4'b0001, 1'b0);
    send(0, 32'h77, 4'b0001, 1'b0);
    send(0, 32'h88, 4'b0001, 1'b1);
    drain();

    // Random packets with random backpressure on all three instances.
    rand_ready = 1'b1;
    fork
      for (int i = 0; i < 400; i++) begin
        up_send(0, 8'($urandom), (i == 399) || ($urandom_range(0, 9) == 0), 1'b1);
        if ($urandom_range(0, 3) == 0) @(posedge clk);
      end
      for (int i = 0; i < 300; i++) begin
        up_send(1, 8'($urandom), (i == 299) || ($urandom_range(0, 9) == 0), 1'b0);
        if ($urandom_range(0, 3) == 0) @(posedge clk);
      end
      for (int i = 0; i < 250; i++) begin
        logic last;
        last = (i == 249) || ($urandom_range(0, 2) == 0);
        dn_send($urandom, last ? int'($urandom_range(0, 4)) : 4, last);
        if ($urandom_range(0, 3) == 0) @(posedge clk);
      end
    join
    drain();
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
